multicycle_ctrl: RTL

//  Multi-cycle control FSM for the 32-bit CPU datapath (16 regs, 4-bit reg fields, 16-bit imm).

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 32-bit
// multi-cycle datapath, with a req/ready handshake towards memory.
module multicycle_ctrl #(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               ir_we,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic               alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         ext_mode,
    output logic               halted,
    output logic               illegal,
    output logic [2:0]         state_dbg
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ILL    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_HALT, C_ILL
    } cls_t;

    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'('h10);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'('h11);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'('h12);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'('h13);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'('h14);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'('h15);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'('h3F);

    state_t             state, state_nx;
    cls_t               cls_d, cls_q;
    logic [OPC_W-1:0]   opc, opc_q;
    logic [1:0]         ext_d, ext_q;
    logic [ALUOP_W-1:0] alu_fn;
    logic               active;
    logic               unused;

    assign opc    = instr[31 -: OPC_W];
    assign alu_fn = opc_q[ALUOP_W-1:0];
    assign unused = &{1'b0, instr[31-OPC_W:0], opc_q[OPC_W-1:ALUOP_W]};

    always_comb begin
        cls_d = C_ILL;
        unique case (1'b1)
            opc[OPC_W-1:3] == '0:                cls_d = C_R;
            opc[OPC_W-1:3] == (OPC_W-3)'(1):     cls_d = C_I;
            opc == OP_LW:                        cls_d = C_LW;
            opc == OP_SW:                        cls_d = C_SW;
            opc == OP_BEQ:                       cls_d = C_BEQ;
            opc == OP_BNE:                       cls_d = C_BNE;
            opc == OP_J:                         cls_d = C_J;
            opc == OP_JAL:                       cls_d = C_JAL;
            opc == OP_HALT:                      cls_d = C_HALT;
            default:                             cls_d = C_ILL;
        endcase
    end

    // Logical immediates (0A/0B) are zero-extended, the rest sign-extended.
    always_comb begin
        ext_d = 2'd0;
        case (cls_d)
            C_I:                      ext_d = (opc[2:1] == 2'b01) ? 2'd0 : 2'd1;
            C_LW, C_SW, C_BEQ, C_BNE: ext_d = 2'd1;
            C_J, C_JAL:               ext_d = 2'd2;
            default:                  ext_d = 2'd0;
        endcase
    end

    // active stays low for the reset cycle so every output is 0 right after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            active <= 1'b0;
            cls_q  <= C_ILL;
            opc_q  <= '0;
            ext_q  <= 2'd0;
        end else begin
            active <= 1'b1;
            state  <= state_nx;
            if (state == S_DECODE) begin
                cls_q <= cls_d;
                opc_q <= opc;
                ext_q <= ext_d;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        ir_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        alu_src_b = 1'b0;
        alu_op    = '0;
        ext_mode  = 2'd0;
        if (active) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we    = 1'b1;
                        pc_we    = 1'b1;
                        state_nx = S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (cls_d)
                        C_HALT:  state_nx = S_HALT;
                        C_ILL:   state_nx = S_ILL;
                        default: state_nx = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    ext_mode = ext_q;
                    state_nx = S_FETCH;
                    unique case (cls_q)
                        C_R, C_I: begin
                            alu_op    = alu_fn;
                            alu_src_b = (cls_q == C_I);
                            state_nx  = S_WB;
                        end
                        C_LW, C_SW: begin
                            alu_src_b = 1'b1;
                            state_nx  = S_MEM;
                        end
                        C_BEQ, C_BNE: begin
                            alu_op = ALUOP_W'(1);
                            if ((cls_q == C_BEQ) == zero) begin
                                pc_we  = 1'b1;
                                pc_sel = 2'd1;
                            end
                        end
                        C_J, C_JAL: begin
                            pc_we  = 1'b1;
                            pc_sel = 2'd2;
                            if (cls_q == C_JAL) begin
                                reg_we = 1'b1;
                                wb_sel = 2'd2;
                            end
                        end
                        default: state_nx = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    addr_sel  = 1'b1;
                    mem_we    = (cls_q == C_SW);
                    alu_src_b = 1'b1;
                    ext_mode  = ext_q;
                    if (mem_ready) begin
                        state_nx = S_FETCH;
                        if (cls_q == C_LW) begin
                            reg_we = 1'b1;
                            wb_sel = 2'd1;
                        end
                    end
                end
                S_WB: begin
                    reg_we    = 1'b1;
                    alu_op    = alu_fn;
                    alu_src_b = (cls_q == C_I);
                    ext_mode  = ext_q;
                    state_nx  = S_FETCH;
                end
                S_HALT:  state_nx = S_HALT;
                S_ILL:   state_nx = S_ILL;
                default: state_nx = S_FETCH;
            endcase
        end
    end

    assign halted    = (state == S_HALT);
    assign illegal   = (state == S_ILL);
    assign state_dbg = state;

endmodule
